// File: rtl/mips_pkg.sv
// Constants shared by the pipeline registers, forwarding unit and write-back register file.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_core.sv
// Raw register storage: async-low clear, one write port, three unmasked combinational read ports.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int NR = NREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  logic [DW-1:0] wData,
  input  logic [AW-1:0] rAddrA,
  input  logic [AW-1:0] rAddrB,
  input  logic [AW-1:0] rAddrC,
  output logic [DW-1:0] rDataA,
  output logic [DW-1:0] rDataB,
  output logic [DW-1:0] rDataC
);

  logic [NR-1:0][DW-1:0] mem;

  // Address is only looked at when we is high, so an X address with we low never corrupts storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rDataA = mem[rAddrA];
  assign rDataB = mem[rAddrB];
  assign rDataC = mem[rAddrC];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it, and serves ID reads with optional same-cycle bypass.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int NREG   = mips_pkg::NREG,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic              memtoReg,
  input  logic [DATA_W-1:0] dataRead,
  input  logic [DATA_W-1:0] aluRes,
  input  logic [ADDR_W-1:0] regWriteAddr,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic              wbValid,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [1:0][ADDR_W-1:0] rdAddr;
  logic [1:0][DATA_W-1:0] rawData;
  logic [1:0][DATA_W-1:0] rdData;
  logic [DATA_W-1:0]      rawDbg;

  assign wbData  = memtoReg ? dataRead : aluRes;
  assign wbValid = regWrite && (regWriteAddr != ZERO_A);

  assign rdAddr[0] = readAddr1;
  assign rdAddr[1] = readAddr2;

  regfile_core #(.DW(DATA_W), .AW(ADDR_W), .NR(NREG)) uCore (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wbValid),
    .wAddr  (regWriteAddr),
    .wData  (wbData),
    .rAddrA (rdAddr[0]),
    .rAddrB (rdAddr[1]),
    .rAddrC (dbgAddr),
    .rDataA (rawData[0]),
    .rDataB (rawData[1]),
    .rDataC (rawDbg)
  );

  // Each ID port resolves independently; r0 masking wins over the bypass.
  for (genvar p = 0; p < 2; p++) begin : gRdPort
    always_comb begin
      rdData[p] = rawData[p];
      if (rdAddr[p] == ZERO_A) begin
        rdData[p] = '0;
      end else if ((BYPASS != 0) && wbValid && (rdAddr[p] == regWriteAddr)) begin
        rdData[p] = wbData;
      end
    end
  end

  assign readData1 = rdData[0];
  assign readData2 = rdData[1];
  assign dbgData   = (dbgAddr == ZERO_A) ? '0 : rawDbg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one BYPASS=1 and one BYPASS=0 instance driven by the same stimulus.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrite, memtoReg;
  logic [31:0] dataRead, aluRes;
  logic [4:0]  regWriteAddr, readAddr1, readAddr2, dbgAddr;
  logic [31:0] rd1B, rd2B, wbB, dbgB;
  logic [31:0] rd1N, rd2N, wbN, dbgN;
  logic        vldB, vldN;
  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .memtoReg(memtoReg),
    .dataRead(dataRead), .aluRes(aluRes), .regWriteAddr(regWriteAddr),
    .readAddr1(readAddr1), .readAddr2(readAddr2), .readData1(rd1B), .readData2(rd2B),
    .wbData(wbB), .wbValid(vldB), .dbgAddr(dbgAddr), .dbgData(dbgB)
  );

  wb_regfile #(.BYPASS(0)) dutNb (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .memtoReg(memtoReg),
    .dataRead(dataRead), .aluRes(aluRes), .regWriteAddr(regWriteAddr),
    .readAddr1(readAddr1), .readAddr2(readAddr2), .readData1(rd1N), .readData2(rd2N),
    .wbData(wbN), .wbValid(vldN), .dbgAddr(dbgAddr), .dbgData(dbgN)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    regWrite = 1'b1; memtoReg = 1'b0; regWriteAddr = a; aluRes = v;
    tick();
    regWrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; regWrite = 1'b1; memtoReg = 1'b0; dataRead = '0;
    aluRes = 32'h1234; regWriteAddr = 5'd5;
    readAddr1 = '0; readAddr2 = '0; dbgAddr = '0;

    // Reset holds storage at zero even with a write pending.
    tick(); tick();
    for (int i = 0; i < 32; i++) begin
      dbgAddr = 5'(i); #1;
      chk("rst_dbgB", dbgB, 32'h0);
      chk("rst_dbgN", dbgN, 32'h0);
    end
    regWrite = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic write then read.
    regWrite = 1'b1; memtoReg = 1'b0; aluRes = 32'hDEADBEEF; regWriteAddr = 5'd8; #1;
    chk("wb_alu", wbB, 32'hDEADBEEF);
    chk("wbValid", {31'b0, vldB}, 32'h1);
    tick();
    regWrite = 1'b0; readAddr1 = 5'd8; #1;
    chk("rd8_B", rd1B, 32'hDEADBEEF);
    chk("rd8_N", rd1N, 32'hDEADBEEF);

    // Mux select memory data.
    regWrite = 1'b1; memtoReg = 1'b1; dataRead = 32'hCAFEF00D; aluRes = 32'h11111111;
    regWriteAddr = 5'd9; #1;
    chk("wb_mem", wbB, 32'hCAFEF00D);
    chk("wb_memN", wbN, 32'hCAFEF00D);
    tick();
    regWrite = 1'b0; dbgAddr = 5'd9; #1;
    chk("dbg9", dbgB, 32'hCAFEF00D);

    // Same-cycle bypass vs stored value.
    wr(5'd3, 32'h5);
    regWrite = 1'b1; memtoReg = 1'b0; aluRes = 32'hA; regWriteAddr = 5'd3;
    readAddr1 = 5'd3; readAddr2 = 5'd3; dbgAddr = 5'd3; #1;
    chk("byp_rd1B", rd1B, 32'hA);
    chk("byp_rd2B", rd2B, 32'hA);
    chk("byp_dbgB", dbgB, 32'h5);
    chk("nob_rd1N", rd1N, 32'h5);
    chk("nob_rd2N", rd2N, 32'h5);
    readAddr2 = 5'd8; #1;
    chk("byp_otherB", rd2B, 32'hDEADBEEF);
    tick();
    regWrite = 1'b0; readAddr2 = 5'd3; #1;
    chk("post_rd1N", rd1N, 32'hA);
    chk("post_rd2N", rd2N, 32'hA);
    chk("post_dbgB", dbgB, 32'hA);

    // Register zero discards writes and masks bypass.
    regWrite = 1'b1; aluRes = 32'hFFFFFFFF; regWriteAddr = 5'd0; readAddr1 = 5'd0; #1;
    chk("r0_pre_B", rd1B, 32'h0);
    chk("r0_pre_N", rd1N, 32'h0);
    chk("r0_valid", {31'b0, vldB}, 32'h0);
    chk("r0_wbData", wbB, 32'hFFFFFFFF);
    tick();
    regWrite = 1'b0; dbgAddr = 5'd0; #1;
    chk("r0_post_B", rd1B, 32'h0);
    chk("r0_dbg", dbgB, 32'h0);

    // Fill, then asynchronous reset mid-cycle with a write pending.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    dbgAddr = 5'd17; #1;
    chk("fill17", dbgB, 32'd17);
    dbgAddr = 5'd31; #1;
    chk("fill31", dbgN, 32'd31);
    regWrite = 1'b1; aluRes = 32'h77; regWriteAddr = 5'd4; readAddr1 = 5'd4;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_rdB_byp", rd1B, 32'h77);
    chk("ar_rdN", rd1N, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbgAddr = 5'(i); #1;
      chk("ar_dbgB", dbgB, 32'h0);
      chk("ar_dbgN", dbgN, 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    regWrite = 1'b0; dbgAddr = 5'd4; #1;
    chk("ar_wr4B", dbgB, 32'h77);
    chk("ar_wr4N", dbgN, 32'h77);
    dbgAddr = 5'd5; #1;
    chk("ar_r5", dbgB, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
